wptr_full_ctrl: RTL

WPTR_FULL_CTRL -- requirements
Module: wptr_full_ctrl

---
 rtl/wptr_full_ctrl_if.sv | 41 ++++
 rtl/wptr_full_ctrl.sv | 102 ++++++++++
 2 files changed

// File: rtl/wptr_full_ctrl_if.sv
// Write-side bus of the asynchronous FIFO write-pointer / full controller.
//   master : producer side; drives the write request, the synchronised Gray read
//            pointer and the almost-full threshold; observes status.
//   slave  : the controller itself (wptr_full_ctrl).
// Signals:
//   winc           write request
//   wq2_rptr       Gray read pointer already synchronised into the write clock
//   afull_val      almost-full threshold in entries
//   wen            memory write enable
//   waddr          binary memory write address
//   wptr           registered Gray write pointer
//   wfull          registered full flag
//   wr_almost_full almost-full flag
//   wr_level       registered occupancy seen from the write side
//   wr_count       accepted-write counter (wraps)
//   wr_overflow    write-while-full error
interface wptr_full_ctrl_if #(
    parameter int ADDRESS_WIDTH = 4
);
    logic                     winc;
    logic [ADDRESS_WIDTH:0]   wq2_rptr;
    logic [ADDRESS_WIDTH:0]   afull_val;
    logic                     wen;
    logic [ADDRESS_WIDTH-1:0] waddr;
    logic [ADDRESS_WIDTH:0]   wptr;
    logic                     wfull;
    logic                     wr_almost_full;
    logic [ADDRESS_WIDTH:0]   wr_level;
    logic [ADDRESS_WIDTH:0]   wr_count;
    logic                     wr_overflow;

    modport master (
        output winc, wq2_rptr, afull_val,
        input  wen, waddr, wptr, wfull, wr_almost_full, wr_level, wr_count, wr_overflow
    );

    modport slave (
        input  winc, wq2_rptr, afull_val,
        output wen, waddr, wptr, wfull, wr_almost_full, wr_level, wr_count, wr_overflow
    );
endinterface

// File: rtl/wptr_full_ctrl.sv
// Write-domain pointer and full/almost-full generation for an asynchronous FIFO.
// Ports:
//   wclk   write-domain clock, all state updates on its rising edge
//   hw_rst asynchronous active-high reset
//   sw_rst synchronous soft reset, honoured only when SOFT_RESET is 2 or 3
//   bus    wptr_full_ctrl_if.slave: winc, wq2_rptr, afull_val in;
//          wen, waddr, wptr, wfull, wr_almost_full, wr_level, wr_count, wr_overflow out
module wptr_full_ctrl #(
    parameter int ADDRESS_WIDTH = 4,
    parameter int DEPTH         = 16,
    parameter int SOFT_RESET    = 0,
    parameter int STICKY_ERROR  = 0
) (
    input logic              wclk,
    input logic              hw_rst,
    input logic              sw_rst,
    wptr_full_ctrl_if.slave  bus
);
    localparam int AW        = ADDRESS_WIDTH;
    localparam bit SOFT_EN   = (SOFT_RESET == 2) || (SOFT_RESET == 3);
    localparam bit STICKY_EN = (STICKY_ERROR == 1);

    if (DEPTH != (1 << ADDRESS_WIDTH)) begin : g_depth_check
        $error("DEPTH must equal 2**ADDRESS_WIDTH");
    end
    if (ADDRESS_WIDTH < 2) begin : g_width_check
        $error("ADDRESS_WIDTH must be at least 2");
    end

    logic [AW:0] wbin_q;
    logic [AW:0] wptr_q;
    logic        wfull_q;
    logic        afull_q;
    logic [AW:0] level_q;
    logic [AW:0] count_q;
    logic        ovf_q;

    logic        wen;
    logic        soft_clr;
    logic        ovf_cond;
    logic [AW:0] wbin_nxt;
    logic [AW:0] wgray_nxt;
    logic [AW:0] full_cmp;
    logic [AW:0] rbin_s;
    logic [AW:0] level_nxt;

    assign wen       = bus.winc & ~wfull_q;
    assign soft_clr  = SOFT_EN & sw_rst;
    assign ovf_cond  = bus.winc & wfull_q;
    assign wbin_nxt  = wbin_q + {{AW{1'b0}}, wen};
    assign wgray_nxt = (wbin_nxt >> 1) ^ wbin_nxt;
    // Full when the write pointer is one lap ahead: top two Gray bits inverted.
    assign full_cmp  = {~bus.wq2_rptr[AW:AW-1], bus.wq2_rptr[AW-2:0]};
    assign level_nxt = wbin_nxt - rbin_s;

    // Gray to binary: each bit is the XOR of itself and all higher bits.
    always_comb begin
        rbin_s = '0;
        for (int i = 0; i <= AW; i++) begin
            rbin_s[i] = ^(bus.wq2_rptr >> i);
        end
    end

    always_ff @(posedge wclk or posedge hw_rst) begin
        if (hw_rst) begin
            wbin_q  <= '0;
            wptr_q  <= '0;
            wfull_q <= 1'b0;
            afull_q <= 1'b0;
            level_q <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else if (soft_clr) begin
            wbin_q  <= '0;
            wptr_q  <= '0;
            wfull_q <= 1'b0;
            afull_q <= 1'b0;
            level_q <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wbin_q  <= wbin_nxt;
            wptr_q  <= wgray_nxt;
            wfull_q <= (wgray_nxt == full_cmp);
            afull_q <= (level_nxt >= bus.afull_val);
            level_q <= level_nxt;
            count_q <= count_q + {{AW{1'b0}}, wen};
            ovf_q   <= STICKY_EN ? (ovf_q | ovf_cond) : ovf_cond;
        end
    end

    assign bus.wen            = wen;
    assign bus.waddr          = wbin_q[AW-1:0];
    assign bus.wptr           = wptr_q;
    assign bus.wfull          = wfull_q;
    // A zero threshold is always met (level >= 0), so forcing the flag here keeps the
    // reset value data-independent in the flop while still reading 1 in and after reset.
    assign bus.wr_almost_full = afull_q | (bus.afull_val == '0);
    assign bus.wr_level       = level_q;
    assign bus.wr_count       = count_q;
    assign bus.wr_overflow    = ovf_q;
endmodule
